bus_memory_responder: RTL and testbench



---
 rtl/bus_pkg.sv | 34 +++
 rtl/responder_line_store.sv | 31 +++
 rtl/bus_memory_responder.sv | 201 ++++++++++++++++++++
 tb/tb_bus_memory_responder.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/bus_pkg.sv
// Shared-bus protocol definitions common to the L2 requester and the memory responder.
// Pure types, constants and helpers; no logic or timing of its own.
package bus_pkg;

    localparam logic [7:0] OP_R = 8'h52;
    localparam logic [7:0] OP_W = 8'h57;
    localparam logic [7:0] OP_M = 8'h4D;
    localparam logic [7:0] OP_I = 8'h49;

    typedef enum logic [1:0] {
        SNP_NOHIT = 2'b00,
        SNP_HIT   = 2'b01,
        SNP_HITM  = 2'b10,
        SNP_RSVD  = 2'b11
    } snoop_t;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_SNOOP,
        ST_WRITEBACK,
        ST_ACCESS,
        ST_RESPOND
    } resp_state_t;

    function automatic logic is_legal_op(input logic [7:0] op);
        return (op == OP_R) || (op == OP_W) || (op == OP_M) || (op == OP_I);
    endfunction

    // The reserved encoding is deliberately folded into a plain hit.
    function automatic logic snoop_is_hit(input snoop_t s);
        return (s == SNP_HIT) || (s == SNP_RSVD);
    endfunction

endpackage

// File: rtl/responder_line_store.sv
// Backing store of whole cache lines: one synchronous write port, one combinational read port.
// Writes land at the rising edge; reads see current contents; synchronous clear on reset.
module responder_line_store #(
    parameter int LINE_SIZE = 512,
    parameter int MEM_LINES = 16,
    parameter int IDX_W     = $clog2(MEM_LINES)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_wr_en,
    input  logic [IDX_W-1:0]     i_wr_idx,
    input  logic [LINE_SIZE-1:0] i_wr_data,
    input  logic [IDX_W-1:0]     i_rd_idx,
    output logic [LINE_SIZE-1:0] o_rd_data
);

    logic [LINE_SIZE-1:0] r_mem [MEM_LINES];

    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            for (int i = 0; i < MEM_LINES; i++) begin
                r_mem[i] <= '0;
            end
        end else if (i_wr_en) begin
            r_mem[i_wr_idx] <= i_wr_data;
        end
    end

    assign o_rd_data = r_mem[i_rd_idx];

endmodule

// File: rtl/bus_memory_responder.sv
// Shared-bus memory responder: snoop window, optional HITM writeback, fixed-latency line access.
// One op in flight; cmd_ready only in IDLE; response held stable until rsp_ready.
module bus_memory_responder
    import bus_pkg::*;
#(
    parameter int LINE_SIZE    = 512,
    parameter int BYTE_SELECT  = 6,
    parameter int MEM_LINES    = 16,
    parameter int SNOOP_WINDOW = 2,
    parameter int READ_LATENCY = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 cmd_valid,
    output logic                 cmd_ready,
    input  logic [7:0]           cmd_op,
    input  logic [31:0]          cmd_addr,
    input  logic [LINE_SIZE-1:0] cmd_wdata,
    input  logic [1:0]           snoop_result,
    input  logic                 snoop_wb_valid,
    input  logic [LINE_SIZE-1:0] snoop_wb_data,
    output logic                 rsp_valid,
    input  logic                 rsp_ready,
    output logic [LINE_SIZE-1:0] rsp_data,
    output logic                 rsp_shared,
    output logic                 rsp_error
);

    localparam int IDX_W   = $clog2(MEM_LINES);
    localparam int CNT_MAX = (SNOOP_WINDOW > READ_LATENCY) ? SNOOP_WINDOW : READ_LATENCY;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] SNOOP_LAST  = CNT_W'(SNOOP_WINDOW - 1);
    localparam logic [CNT_W-1:0] ACCESS_LAST = CNT_W'(READ_LATENCY - 1);

    resp_state_t          r_state;
    resp_state_t          w_state_nxt;
    logic [7:0]           r_op;
    logic [IDX_W-1:0]     r_idx;
    logic [LINE_SIZE-1:0] r_wdata;
    logic [CNT_W-1:0]     r_cnt;
    logic                 r_hit;
    logic                 r_hitm;
    logic [LINE_SIZE-1:0] r_rsp_data;
    logic                 r_rsp_shared;
    logic                 r_rsp_error;

    snoop_t               w_snoop;
    logic                 w_hit_nxt;
    logic                 w_hitm_nxt;
    logic                 w_snoop_last;
    logic                 w_access_last;
    logic                 w_accept;
    logic                 w_op_is_i;
    logic                 w_wr_en;
    logic [LINE_SIZE-1:0] w_wr_data;
    logic [LINE_SIZE-1:0] w_rd_data;
    logic                 w_unused_addr;

    assign w_snoop       = snoop_t'(snoop_result);
    assign w_hit_nxt     = r_hit | snoop_is_hit(w_snoop);
    assign w_hitm_nxt    = r_hitm | (w_snoop == SNP_HITM);
    assign w_snoop_last  = (r_state == ST_SNOOP) && (r_cnt == SNOOP_LAST);
    assign w_access_last = (r_state == ST_ACCESS) && (r_cnt == ACCESS_LAST);
    assign w_accept      = (r_state == ST_IDLE) && cmd_valid;
    assign w_op_is_i     = (r_op == OP_I);
    // Bits above the index alias onto the same line; offset bits select nothing.
    assign w_unused_addr = ^cmd_addr;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE: begin
                if (cmd_valid) begin
                    w_state_nxt = is_legal_op(cmd_op) ? ST_SNOOP : ST_RESPOND;
                end
            end
            ST_SNOOP: begin
                if (w_snoop_last) begin
                    if (w_hitm_nxt) begin
                        w_state_nxt = ST_WRITEBACK;
                    end else begin
                        w_state_nxt = w_op_is_i ? ST_RESPOND : ST_ACCESS;
                    end
                end
            end
            ST_WRITEBACK: begin
                if (snoop_wb_valid) begin
                    w_state_nxt = w_op_is_i ? ST_RESPOND : ST_ACCESS;
                end
            end
            ST_ACCESS: begin
                if (w_access_last) begin
                    w_state_nxt = ST_RESPOND;
                end
            end
            ST_RESPOND: begin
                if (rsp_ready) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    always_comb begin
        cmd_ready = 1'b0;
        rsp_valid = 1'b0;
        w_wr_en   = 1'b0;
        w_wr_data = r_wdata;
        case (r_state)
            ST_IDLE:    cmd_ready = 1'b1;
            ST_RESPOND: rsp_valid = 1'b1;
            ST_WRITEBACK: begin
                w_wr_en   = snoop_wb_valid;
                w_wr_data = snoop_wb_data;
            end
            ST_ACCESS: begin
                w_wr_en = w_access_last && (r_op == OP_W);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_op         <= '0;
            r_idx        <= '0;
            r_wdata      <= '0;
            r_cnt        <= '0;
            r_hit        <= 1'b0;
            r_hitm       <= 1'b0;
            r_rsp_data   <= '0;
            r_rsp_shared <= 1'b0;
            r_rsp_error  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_op         <= cmd_op;
                        r_idx        <= cmd_addr[BYTE_SELECT +: IDX_W];
                        r_wdata      <= cmd_wdata;
                        r_cnt        <= '0;
                        r_hit        <= 1'b0;
                        r_hitm       <= 1'b0;
                        r_rsp_data   <= '0;
                        r_rsp_shared <= 1'b0;
                        r_rsp_error  <= !is_legal_op(cmd_op);
                    end
                end
                ST_SNOOP: begin
                    r_hit  <= w_hit_nxt;
                    r_hitm <= w_hitm_nxt;
                    r_cnt  <= w_snoop_last ? '0 : r_cnt + CNT_W'(1);
                end
                ST_ACCESS: begin
                    r_cnt <= w_access_last ? '0 : r_cnt + CNT_W'(1);
                    // Read sees the store after any writeback committed in WRITEBACK.
                    if (w_access_last && (r_op == OP_R || r_op == OP_M)) begin
                        r_rsp_data   <= w_rd_data;
                        r_rsp_shared <= (r_op == OP_R) && (r_hit || r_hitm);
                    end
                end
                ST_RESPOND: begin
                    if (rsp_ready) begin
                        r_rsp_data   <= '0;
                        r_rsp_shared <= 1'b0;
                        r_rsp_error  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign rsp_data   = r_rsp_data;
    assign rsp_shared = r_rsp_shared;
    assign rsp_error  = r_rsp_error;

    responder_line_store #(
        .LINE_SIZE (LINE_SIZE),
        .MEM_LINES (MEM_LINES),
        .IDX_W     (IDX_W)
    ) u_line_store (
        .i_clk     (clk),
        .i_rst_n   (rst_n),
        .i_wr_en   (w_wr_en),
        .i_wr_idx  (r_idx),
        .i_wr_data (w_wr_data),
        .i_rd_idx  (r_idx),
        .o_rd_data (w_rd_data)
    );

endmodule

// File: tb/tb_bus_memory_responder.sv
// Directed and randomized bench for bus_memory_responder against a line-level reference model.
module tb_bus_memory_responder;

    localparam int LS = 512;
    localparam int BS = 6;
    localparam int ML = 16;
    localparam int SW = 2;
    localparam int RL = 4;

    localparam logic [7:0] T_R = 8'h52;
    localparam logic [7:0] T_W = 8'h57;
    localparam logic [7:0] T_M = 8'h4D;
    localparam logic [7:0] T_I = 8'h49;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          cmd_valid;
    logic          cmd_ready;
    logic [7:0]    cmd_op;
    logic [31:0]   cmd_addr;
    logic [LS-1:0] cmd_wdata;
    logic [1:0]    snoop_result;
    logic          snoop_wb_valid;
    logic [LS-1:0] snoop_wb_data;
    logic          rsp_valid;
    logic          rsp_ready;
    logic [LS-1:0] rsp_data;
    logic          rsp_shared;
    logic          rsp_error;

    int total = 0;
    int bad   = 0;
    logic [LS-1:0] mem [ML];

    bus_memory_responder #(
        .LINE_SIZE    (LS),
        .BYTE_SELECT  (BS),
        .MEM_LINES    (ML),
        .SNOOP_WINDOW (SW),
        .READ_LATENCY (RL)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .cmd_valid      (cmd_valid),
        .cmd_ready      (cmd_ready),
        .cmd_op         (cmd_op),
        .cmd_addr       (cmd_addr),
        .cmd_wdata      (cmd_wdata),
        .snoop_result   (snoop_result),
        .snoop_wb_valid (snoop_wb_valid),
        .snoop_wb_data  (snoop_wb_data),
        .rsp_valid      (rsp_valid),
        .rsp_ready      (rsp_ready),
        .rsp_data       (rsp_data),
        .rsp_shared     (rsp_shared),
        .rsp_error      (rsp_error)
    );

    always #5 clk = ~clk;

    task automatic check_bit(input string tag, input string name, input logic obs, input logic exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%b expected=%b", tag, name, obs, exp);
        end
    endtask

    task automatic check_int(input string tag, input string name, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0d expected=%0d", tag, name, obs, exp);
        end
    endtask

    task automatic check_line(input string tag, input string name, input logic [LS-1:0] obs,
                              input logic [LS-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s/%s observed=%0h expected=%0h", tag, name, obs, exp);
        end
    endtask

    function automatic logic [LS-1:0] rnd_line();
        logic [LS-1:0] v;
        for (int i = 0; i < LS / 32; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    task automatic check_idle_outputs(input string tag);
        check_bit(tag, "cmd_ready", cmd_ready, 1'b1);
        check_bit(tag, "rsp_valid", rsp_valid, 1'b0);
        check_line(tag, "rsp_data", rsp_data, '0);
        check_bit(tag, "rsp_shared", rsp_shared, 1'b0);
        check_bit(tag, "rsp_error", rsp_error, 1'b0);
    endtask

    // One complete operation: model prediction, bus drive, latency/response/hold/turnaround checks.
    task automatic run_op(input string tag, input logic [7:0] op, input logic [31:0] addr,
                          input logic [LS-1:0] wd, input logic [1:0] s0, input logic [1:0] s1,
                          input int wb_wait, input logic [LS-1:0] wbd, input int hold,
                          input bit noise);
        logic [1:0]    snp [SW];
        bit            legal, hit, hitm, in_wb, busy_ok, stable_ok;
        int            idx, extra, exp_lat, cyc;
        logic [LS-1:0] exp_data;
        logic          exp_sh, exp_err;

        snp[0] = s0;
        snp[1] = s1;
        legal = op inside {T_R, T_W, T_M, T_I};
        idx   = int'((addr >> BS) % ML);
        hit = 0;
        hitm = 0;
        for (int k = 0; k < SW; k++) begin
            if (snp[k] == 2'b01 || snp[k] == 2'b11) hit = 1;
            if (snp[k] == 2'b10) hitm = 1;
        end
        exp_data = '0;
        exp_sh   = 1'b0;
        exp_err  = !legal;
        extra    = (legal && hitm) ? wb_wait : 0;
        if (!legal) begin
            exp_lat = 1;
        end else begin
            if (hitm) mem[idx] = wbd;
            if (op == T_I) begin
                exp_lat = SW + extra + 1;
            end else begin
                exp_lat = SW + extra + RL + 1;
                if (op == T_W) mem[idx] = wd;
                else exp_data = mem[idx];
                exp_sh = (op == T_R) && (hit || hitm);
            end
        end

        @(negedge clk);
        check_bit(tag, "accept_ready", cmd_ready, 1'b1);
        cmd_valid = 1'b1;
        cmd_op    = op;
        cmd_addr  = addr;
        cmd_wdata = wd;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        cmd_op    = 8'h00;
        cyc       = 1;
        busy_ok   = 1;
        while (cyc <= 60) begin
            if (cyc <= SW) snoop_result = snp[cyc-1];
            else snoop_result = noise ? 2'($urandom) : 2'b00;
            in_wb = legal && hitm && (cyc > SW) && (cyc <= SW + wb_wait);
            if (in_wb) begin
                snoop_wb_valid = (cyc == SW + wb_wait);
                snoop_wb_data  = wbd;
            end else begin
                snoop_wb_valid = noise ? 1'($urandom) : 1'b0;
                snoop_wb_data  = rnd_line();
            end
            @(negedge clk);
            if (rsp_valid) break;
            if (cmd_ready) busy_ok = 0;
            @(posedge clk);
            #1;
            cyc++;
        end
        snoop_wb_valid = 1'b0;
        check_bit(tag, "busy_ready_low", busy_ok, 1'b1);
        check_int(tag, "rsp_latency", cyc, exp_lat);
        check_bit(tag, "respond_ready_low", cmd_ready, 1'b0);
        check_line(tag, "rsp_data", rsp_data, exp_data);
        check_bit(tag, "rsp_shared", rsp_shared, exp_sh);
        check_bit(tag, "rsp_error", rsp_error, exp_err);

        stable_ok = 1;
        for (int h = 0; h < hold; h++) begin
            @(posedge clk);
            #1;
            snoop_result   = noise ? 2'($urandom) : 2'b00;
            snoop_wb_valid = noise ? 1'($urandom) : 1'b0;
            @(negedge clk);
            if (rsp_valid !== 1'b1 || cmd_ready !== 1'b0 || rsp_data !== exp_data ||
                rsp_shared !== exp_sh || rsp_error !== exp_err) stable_ok = 0;
        end
        if (hold > 0) check_bit(tag, "hold_stable", stable_ok, 1'b1);

        rsp_ready = 1'b1;
        @(posedge clk);
        #1;
        rsp_ready      = 1'b0;
        snoop_result   = 2'b00;
        snoop_wb_valid = 1'b0;
        @(negedge clk);
        check_bit(tag, "turnaround_ready", cmd_ready, 1'b1);
        check_bit(tag, "turnaround_valid", rsp_valid, 1'b0);
    endtask

    initial begin
        logic [7:0]  op;
        logic [31:0] addr;
        int          sel;

        rst_n          = 1'b0;
        cmd_valid      = 1'b0;
        cmd_op         = 8'h00;
        cmd_addr       = 32'h0;
        cmd_wdata      = '0;
        snoop_result   = 2'b00;
        snoop_wb_valid = 1'b0;
        snoop_wb_data  = '0;
        rsp_ready      = 1'b0;
        for (int i = 0; i < ML; i++) mem[i] = '0;

        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(negedge clk);
        check_idle_outputs("reset");

        run_op("r40_nohit", T_R, 32'h40, '0, 2'b00, 2'b00, 1, '0, 0, 0);
        run_op("w80", T_W, 32'h80, {16{32'hA5A5A5A5}}, 2'b00, 2'b00, 1, '0, 0, 0);
        run_op("r80_hit", T_R, 32'h80, '0, 2'b01, 2'b00, 1, '0, 0, 0);
        run_op("rC0_hitm", T_R, 32'hC0, '0, 2'b00, 2'b10, 3, {16{32'h12345678}}, 0, 0);
        run_op("m40_hit", T_M, 32'h40, '0, 2'b01, 2'b01, 1, '0, 0, 0);
        run_op("i40_nohit", T_I, 32'h40, '0, 2'b00, 2'b00, 1, '0, 0, 0);
        run_op("err_X", 8'h58, 32'h40, '0, 2'b00, 2'b00, 1, '0, 5, 0);
        run_op("r_rsvd_alias", T_R, 32'hFFFF_F880, '0, 2'b11, 2'b00, 1, '0, 2, 0);
        run_op("i_hitm", T_I, 32'h100, '0, 2'b10, 2'b00, 2, {16{32'hCAFEF00D}}, 0, 0);
        run_op("m_hitm_wb", T_M, 32'h100, '0, 2'b00, 2'b01, 1, '0, 1, 0);

        // Reset while a W sits in ACCESS: nothing may be committed.
        @(negedge clk);
        cmd_valid = 1'b1;
        cmd_op    = T_W;
        cmd_addr  = 32'h80;
        cmd_wdata = {16{32'h5A5A5A5A}};
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        for (int i = 0; i < ML; i++) mem[i] = '0;
        @(negedge clk);
        check_idle_outputs("reset_mid_access");
        run_op("r80_after_reset", T_R, 32'h80, '0, 2'b00, 2'b00, 1, '0, 0, 0);
        run_op("rC0_after_reset", T_R, 32'hC0, '0, 2'b00, 2'b00, 1, '0, 0, 0);

        for (int n = 0; n < 60; n++) begin
            sel = $urandom_range(0, 9);
            if (sel < 3) op = T_R;
            else if (sel < 5) op = T_W;
            else if (sel < 7) op = T_M;
            else if (sel < 9) op = T_I;
            else begin
                op = 8'($urandom);
                while (op inside {T_R, T_W, T_M, T_I}) op = 8'($urandom);
            end
            addr = $urandom;
            addr[BS+3:BS] = 4'($urandom_range(0, 3));
            run_op($sformatf("rnd%0d", n), op, addr, rnd_line(), 2'($urandom), 2'($urandom),
                   $urandom_range(1, 4), rnd_line(), $urandom_range(0, 2), 1);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
